// File: rtl/usb3_ext_in_packer_if.sv
// Stream-input and endpoint-buffer signals of the USB3 bulk IN packer.
// slave is the packer's view; master is the source / protocol-layer view.
interface usb3_ext_in_packer_if;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        s_last;
  logic [1:0]  s_last_bytes;
  logic [8:0]  ext_buf_in_addr;
  logic [31:0] ext_buf_in_data;
  logic        ext_buf_in_wren;
  logic        ext_buf_in_ready;
  logic        ext_buf_in_commit;
  logic [10:0] ext_buf_in_commit_len;
  logic        ext_buf_in_commit_ack;
  logic        ext_buf_in_request;

  modport slave (
    input  s_data, s_valid, s_last, s_last_bytes,
    input  ext_buf_in_ready, ext_buf_in_commit_ack, ext_buf_in_request,
    output s_ready,
    output ext_buf_in_addr, ext_buf_in_data, ext_buf_in_wren,
    output ext_buf_in_commit, ext_buf_in_commit_len
  );

  modport master (
    output s_data, s_valid, s_last, s_last_bytes,
    output ext_buf_in_ready, ext_buf_in_commit_ack, ext_buf_in_request,
    input  s_ready,
    input  ext_buf_in_addr, ext_buf_in_data, ext_buf_in_wren,
    input  ext_buf_in_commit, ext_buf_in_commit_len
  );
endinterface

// File: rtl/usb3_ext_in_packer.sv
// Packs a 32-bit word stream into USB3 bulk IN packets in the EP1 IN buffer,
// committing on full size, end of transfer, source stall timeout or host request.
module usb3_ext_in_packer #(
  parameter int MAX_WORDS     = 256,
  parameter int FLUSH_TIMEOUT = 1024
) (
  input  logic                ext_clk,
  input  logic                reset,
  usb3_ext_in_packer_if.slave bus,
  output logic [15:0]         pkt_count,
  output logic [15:0]         flush_count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_COMMIT
  } state_e;

  localparam logic [8:0]  WCNT_LAST  = 9'(MAX_WORDS - 1);
  localparam logic [10:0] FULL_LEN   = 11'(MAX_WORDS * 4);
  localparam logic [15:0] TIMEOUT_M1 = 16'(FLUSH_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [8:0]  wcnt_q, wcnt_d;
  logic [15:0] idle_cnt_q, idle_cnt_d;
  logic [8:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        wren_q, wren_d;
  logic        commit_q, commit_d;
  logic [10:0] len_q, len_d;
  logic [15:0] pkt_q, pkt_d;
  logic [15:0] flush_q, flush_d;

  logic        in_fill;
  logic        accept;
  logic        end_pkt;
  logic        flush_go;
  logic        ack_go;
  logic [10:0] last_len;

  assign in_fill  = (state_q == ST_FILL);
  assign accept   = in_fill & bus.s_valid;
  assign end_pkt  = accept & (bus.s_last | (wcnt_q == WCNT_LAST));
  // A flush only fires on a cycle with no word, so s_last always wins a tie.
  assign flush_go = in_fill & ~bus.s_valid & (wcnt_q != 9'd0) &
                    ((idle_cnt_q == TIMEOUT_M1) | bus.ext_buf_in_request);
  assign ack_go   = (state_q == ST_COMMIT) & commit_q & bus.ext_buf_in_commit_ack;
  assign last_len = (bus.s_last_bytes == 2'd0) ? 11'd4 : {9'd0, bus.s_last_bytes};

  // State register.
  always_ff @(posedge ext_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.ext_buf_in_ready) state_d = ST_FILL;
      end
      ST_FILL: begin
        if (end_pkt || flush_go)        state_d = ST_COMMIT;
        else if (!bus.ext_buf_in_ready) state_d = ST_IDLE;
      end
      ST_COMMIT: begin
        if (ack_go) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode: the source is only ever accepted while filling.
  always_comb begin
    bus.s_ready = in_fill;
  end

  // Datapath next values.
  always_comb begin
    wcnt_d     = wcnt_q;
    idle_cnt_d = idle_cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    wren_d     = 1'b0;
    len_d      = len_q;
    pkt_d      = pkt_q;
    flush_d    = flush_q;
    commit_d   = (state_q == ST_COMMIT) & ~ack_go;

    if (accept) begin
      addr_d     = wcnt_q;
      data_d     = bus.s_data;
      wren_d     = 1'b1;
      wcnt_d     = wcnt_q + 9'd1;
      idle_cnt_d = 16'd0;
      if (bus.s_last) begin
        len_d = {wcnt_q, 2'b00} + last_len;
      end else if (end_pkt) begin
        len_d = FULL_LEN;
      end
    end else if (in_fill && (wcnt_q != 9'd0)) begin
      if (idle_cnt_q != 16'hFFFF) idle_cnt_d = idle_cnt_q + 16'd1;
      if (flush_go) begin
        len_d   = {wcnt_q, 2'b00};
        flush_d = flush_q + 16'd1;
      end
    end

    if (ack_go) begin
      pkt_d      = pkt_q + 16'd1;
      wcnt_d     = 9'd0;
      idle_cnt_d = 16'd0;
    end
  end

  // Datapath registers; a reset drops any partial or pending packet.
  always_ff @(posedge ext_clk) begin
    if (reset) begin
      wcnt_q     <= 9'd0;
      idle_cnt_q <= 16'd0;
      addr_q     <= 9'd0;
      data_q     <= 32'd0;
      wren_q     <= 1'b0;
      commit_q   <= 1'b0;
      len_q      <= 11'd0;
      pkt_q      <= 16'd0;
      flush_q    <= 16'd0;
    end else begin
      wcnt_q     <= wcnt_d;
      idle_cnt_q <= idle_cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      wren_q     <= wren_d;
      commit_q   <= commit_d;
      len_q      <= len_d;
      pkt_q      <= pkt_d;
      flush_q    <= flush_d;
    end
  end

  assign bus.ext_buf_in_addr       = addr_q;
  assign bus.ext_buf_in_data       = data_q;
  assign bus.ext_buf_in_wren       = wren_q;
  assign bus.ext_buf_in_commit     = commit_q;
  assign bus.ext_buf_in_commit_len = len_q;
  assign pkt_count                 = pkt_q;
  assign flush_count               = flush_q;

endmodule
